// File: rtl/genius_ctrl_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : genius_ctrl_gen_pkg
// Purpose  : Shared types for the Genius game controller: FSM state encoding,
//            the datapath control bundle, and the per-state control decode.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package genius_ctrl_gen_pkg;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_SETUP      = 3'd1,
    S_PLAY_FPGA  = 3'd2,
    S_PLAY_USER  = 3'd3,
    S_CHECK      = 3'd4,
    S_NEXT_ROUND = 3'd5,
    S_LOSE       = 3'd6,
    S_RESULT     = 3'd7
  } state_t;

  // Datapath control strobes, held in registers alongside the state.
  typedef struct packed {
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
  } ctrl_t;

  // Value driven while reset is asserted: only the game registers are reset.
  localparam ctrl_t C_CTRL_RESET = 7'b100_0000;

  // Control strobes for the state being entered. lose_r2 selects whether a
  // LOSE cycle resets the per-round user registers (a retry follows) or not
  // (the game is over and the user entry must stay visible).
  function automatic ctrl_t ctrl_of(input state_t s, input logic lose_r2);
    ctrl_t c;
    c = '0;
    case (s)
      S_INIT:       begin c.r1 = 1'b1; c.r2 = 1'b1; end
      S_SETUP:      c.e1 = 1'b1;
      S_PLAY_FPGA:  c.e2 = 1'b1;
      S_PLAY_USER:  c.e3 = 1'b1;
      S_NEXT_ROUND: c.r2 = 1'b1;
      S_LOSE:       c.r2 = lose_r2;
      S_RESULT:     begin c.e4 = 1'b1; c.sel = 1'b1; end
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/genius_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : genius_idle_timer
// Purpose  : User-inactivity timer. Counts cycles while running, restarts on
//            any key press, flags expiry on the TIMEOUT-th idle cycle.
// Ports    : clk, rst         clock / asynchronous active-high reset
//            i_clear          force count to zero
//            i_run            count this cycle
//            i_key_press      user activity; restarts the count
//            o_expired        combinational pulse: last allowed idle cycle
// Revision : 1.0 - initial release
// ============================================================================
module genius_idle_timer #(
  parameter int TW      = 26,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  input  logic i_key_press,
  output logic o_expired
);

  localparam logic [TW-1:0] C_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= i_key_press ? '0 : r_count + TW'(1);
    end
  end

  // A key press in the expiry cycle rescues the user.
  assign o_expired = i_run & ~i_key_press & (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/genius_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : genius_ctrl_gen
// Purpose  : Genius (Simon) game controller. Sequences FPGA playback, user
//            entry, check and result phases; drives datapath resets/enables;
//            tracks round, lives and an internal inactivity timeout.
// Ports    : CLOCK, reset     clock / asynchronous active-high reset
//            enter            start / confirm pulse
//            end_FPGA         playback of current sequence finished
//            end_User         user entry of current sequence finished
//            key_press        user activity this cycle
//            match            user sequence equals FPGA sequence (CHECK)
//            R1, R2           reset game regs / per-round user regs
//            E1..E4           setup / FPGA counter / user entry / result enables
//            SEL              display mux (1 = result view)
//            round, lives     status (round is 0-based)
//            victory, defeat  game outcome, valid in RESULT
// Revision : 1.0 - initial release
// ============================================================================
module genius_ctrl_gen #(
  parameter int N_ROUNDS  = 16,
  parameter int RW        = 4,
  parameter int MAX_LIVES = 3,
  parameter int TIMEOUT   = 50_000_000,
  parameter int TW        = 26
) (
  input  logic          CLOCK,
  input  logic          reset,
  input  logic          enter,
  input  logic          end_FPGA,
  input  logic          end_User,
  input  logic          key_press,
  input  logic          match,
  output logic          R1,
  output logic          R2,
  output logic          E1,
  output logic          E2,
  output logic          E3,
  output logic          E4,
  output logic          SEL,
  output logic [RW-1:0] round,
  output logic [2:0]    lives,
  output logic          victory,
  output logic          defeat
);

  import genius_ctrl_gen_pkg::*;

  localparam logic [RW-1:0] C_LAST_ROUND = RW'(N_ROUNDS - 1);
  localparam logic [2:0]    C_MAX_LIVES  = 3'(MAX_LIVES);

  state_t        r_state;
  ctrl_t         r_ctrl;
  logic [RW-1:0] r_round;
  logic [2:0]    r_lives;
  logic          r_victory;
  logic          r_defeat;
  logic          w_expired;
  logic          w_in_user;
  logic          w_lose_r2;

  assign w_in_user = (r_state == S_PLAY_USER);
  // A loss resets the user registers only when a retry will follow.
  assign w_lose_r2 = (r_lives != 3'd1);

  genius_idle_timer #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk         (CLOCK),
    .rst         (reset),
    .i_clear     (~w_in_user),
    .i_run       (w_in_user),
    .i_key_press (key_press),
    .o_expired   (w_expired)
  );

  // Control strobes are registered together with the state, decoded for the
  // state being entered, so every output is glitch-free and changes on the
  // same edge as the state. After an async reset the INIT cycle shows R1 only.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      r_state   <= S_INIT;
      r_ctrl    <= C_CTRL_RESET;
      r_round   <= '0;
      r_lives   <= C_MAX_LIVES;
      r_victory <= 1'b0;
      r_defeat  <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_victory <= 1'b0;
          r_defeat  <= 1'b0;
          r_state   <= S_SETUP;
          r_ctrl    <= ctrl_of(S_SETUP, 1'b0);
        end
        S_SETUP: begin
          r_round <= '0;
          r_lives <= C_MAX_LIVES;
          if (enter) begin
            r_state <= S_PLAY_FPGA;
            r_ctrl  <= ctrl_of(S_PLAY_FPGA, 1'b0);
          end
        end
        S_PLAY_FPGA: begin
          if (end_FPGA) begin
            r_state <= S_PLAY_USER;
            r_ctrl  <= ctrl_of(S_PLAY_USER, 1'b0);
          end
        end
        S_PLAY_USER: begin
          // Finishing the entry takes priority over a simultaneous timeout.
          if (end_User) begin
            r_state <= S_CHECK;
            r_ctrl  <= ctrl_of(S_CHECK, 1'b0);
          end else if (w_expired) begin
            r_state <= S_LOSE;
            r_ctrl  <= ctrl_of(S_LOSE, w_lose_r2);
          end
        end
        S_CHECK: begin
          if (!match) begin
            r_state <= S_LOSE;
            r_ctrl  <= ctrl_of(S_LOSE, w_lose_r2);
          end else if (r_round == C_LAST_ROUND) begin
            r_victory <= 1'b1;
            r_state   <= S_RESULT;
            r_ctrl    <= ctrl_of(S_RESULT, 1'b0);
          end else begin
            r_state <= S_NEXT_ROUND;
            r_ctrl  <= ctrl_of(S_NEXT_ROUND, 1'b0);
          end
        end
        S_NEXT_ROUND: begin
          if (r_round != C_LAST_ROUND) begin
            r_round <= r_round + RW'(1);
          end
          r_state <= S_PLAY_FPGA;
          r_ctrl  <= ctrl_of(S_PLAY_FPGA, 1'b0);
        end
        S_LOSE: begin
          if (r_lives != 3'd0) begin
            r_lives <= r_lives - 3'd1;
          end
          if (r_lives <= 3'd1) begin
            r_defeat <= 1'b1;
            r_state  <= S_RESULT;
            r_ctrl   <= ctrl_of(S_RESULT, 1'b0);
          end else begin
            r_state <= S_PLAY_FPGA;
            r_ctrl  <= ctrl_of(S_PLAY_FPGA, 1'b0);
          end
        end
        S_RESULT: begin
          if (enter) begin
            r_victory <= 1'b0;
            r_defeat  <= 1'b0;
            r_state   <= S_INIT;
            r_ctrl    <= ctrl_of(S_INIT, 1'b0);
          end
        end
        default: begin
          r_state <= S_INIT;
          r_ctrl  <= ctrl_of(S_INIT, 1'b0);
        end
      endcase
    end
  end

  assign R1      = r_ctrl.r1;
  assign R2      = r_ctrl.r2;
  assign E1      = r_ctrl.e1;
  assign E2      = r_ctrl.e2;
  assign E3      = r_ctrl.e3;
  assign E4      = r_ctrl.e4;
  assign SEL     = r_ctrl.sel;
  assign round   = r_round;
  assign lives   = r_lives;
  assign victory = r_victory;
  assign defeat  = r_defeat;

endmodule
`default_nettype wire

// File: tb/tb_genius_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_genius_ctrl_gen
// Purpose  : Self-checking bench for genius_ctrl_gen (4 rounds, 3 lives,
//            8-cycle timeout). Directed vector table, hand-written corner
//            sequences and randomized traffic against a game-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_genius_ctrl_gen;

  localparam int N_ROUNDS  = 4;
  localparam int RW        = 2;
  localparam int MAX_LIVES = 3;
  localparam int TIMEOUT   = 8;
  localparam int TW        = 4;

  // Output bundle order: {R1,R2,E1,E2,E3,E4,SEL,victory,defeat}
  localparam logic [8:0] O_RST   = 9'b100000000;
  localparam logic [8:0] O_INIT  = 9'b110000000;
  localparam logic [8:0] O_SETUP = 9'b001000000;
  localparam logic [8:0] O_FPGA  = 9'b000100000;
  localparam logic [8:0] O_USER  = 9'b000010000;
  localparam logic [8:0] O_CHECK = 9'b000000000;
  localparam logic [8:0] O_R2    = 9'b010000000;
  localparam logic [8:0] O_RES_V = 9'b000001110;
  localparam logic [8:0] O_RES_D = 9'b000001101;

  // Game phases of the reference model.
  localparam int P_INIT = 0, P_SETUP = 1, P_FPGA = 2, P_USER = 3;
  localparam int P_CHECK = 4, P_NEXT = 5, P_LOSE = 6, P_RESULT = 7;

  logic          CLOCK = 1'b0;
  logic          reset;
  logic          enter, end_FPGA, end_User, key_press, match;
  logic          R1, R2, E1, E2, E3, E4, SEL, victory, defeat;
  logic [RW-1:0] round;
  logic [2:0]    lives;
  logic [8:0]    dut_o;

  assign dut_o = {R1, R2, E1, E2, E3, E4, SEL, victory, defeat};

  genius_ctrl_gen #(
    .N_ROUNDS (N_ROUNDS), .RW (RW), .MAX_LIVES (MAX_LIVES),
    .TIMEOUT (TIMEOUT), .TW (TW)
  ) dut (
    .CLOCK (CLOCK), .reset (reset), .enter (enter), .end_FPGA (end_FPGA),
    .end_User (end_User), .key_press (key_press), .match (match),
    .R1 (R1), .R2 (R2), .E1 (E1), .E2 (E2), .E3 (E3), .E4 (E4), .SEL (SEL),
    .round (round), .lives (lives), .victory (victory), .defeat (defeat)
  );

  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int m_phase, m_idle, m_round, m_lives;
  bit m_vic, m_def, m_fresh;

  function automatic void model_reset();
    m_phase = P_INIT; m_idle = 0; m_round = 0; m_lives = MAX_LIVES;
    m_vic = 0; m_def = 0; m_fresh = 1;
  endfunction

  function automatic logic [8:0] m_out();
    logic [8:0] o;
    o = '0;
    case (m_phase)
      P_INIT:   o = m_fresh ? O_RST : O_INIT;
      P_SETUP:  o = O_SETUP;
      P_FPGA:   o = O_FPGA;
      P_USER:   o = O_USER;
      P_NEXT:   o = O_R2;
      P_LOSE:   o = (m_lives > 1) ? O_R2 : 9'b0;
      P_RESULT: o = 9'b000001100;
      default:  o = '0;
    endcase
    o[1] = m_vic;
    o[0] = m_def;
    return o;
  endfunction

  function automatic void model_step(input bit en, ef, eu, kp, m);
    case (m_phase)
      P_INIT:  begin m_phase = P_SETUP; m_vic = 0; m_def = 0; end
      P_SETUP: begin
        m_round = 0; m_lives = MAX_LIVES;
        if (en) m_phase = P_FPGA;
      end
      P_FPGA: begin m_idle = 0; if (ef) m_phase = P_USER; end
      P_USER: begin
        if (eu) m_phase = P_CHECK;
        else if (kp) m_idle = 0;
        else if (m_idle >= TIMEOUT - 1) m_phase = P_LOSE;
        else m_idle++;
      end
      P_CHECK: begin
        if (!m) m_phase = P_LOSE;
        else if (m_round == N_ROUNDS - 1) begin m_phase = P_RESULT; m_vic = 1; end
        else m_phase = P_NEXT;
      end
      P_NEXT: begin
        if (m_round < N_ROUNDS - 1) m_round++;
        m_phase = P_FPGA; m_idle = 0;
      end
      P_LOSE: begin
        if (m_lives <= 1) begin m_phase = P_RESULT; m_def = 1; end
        else m_phase = P_FPGA;
        if (m_lives > 0) m_lives--;
        m_idle = 0;
      end
      P_RESULT: if (en) begin m_phase = P_INIT; m_fresh = 0; m_vic = 0; m_def = 0; end
      default: m_phase = P_INIT;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    logic [13:0] e;
    logic [1:0]  r;
    logic [2:0]  l;
    r = 2'(m_round);
    l = 3'(m_lives);
    e = {m_out(), r, l};
    chk(name, int'({dut_o, round, lives}), int'(e));
  endtask

  task automatic tick(input bit en, ef, eu, kp, m, input string name);
    enter = en; end_FPGA = ef; end_User = eu; key_press = kp; match = m;
    @(posedge CLOCK);
    model_step(en, ef, eu, kp, m);
    @(negedge CLOCK);
    chk_model(name);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, "idle");
  endtask

  // Full matched round from PLAY_FPGA back to PLAY_FPGA (next round).
  task automatic win_round();
    tick(0, 1, 0, 0, 0, "wr_fpga");
    tick(0, 0, 1, 0, 0, "wr_user");
    tick(0, 0, 0, 0, 1, "wr_check");
    tick(0, 0, 0, 0, 0, "wr_next");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit en, ef, eu, kp, m;
    logic [8:0] o;
    int rnd;
    int lv;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [1:0] vr;
    logic [2:0] vl;

    tbl[0]  = '{0, 0, 0, 0, 0, O_SETUP, 0, 3};
    tbl[1]  = '{0, 1, 0, 0, 1, O_SETUP, 0, 3};  // end_FPGA/match ignored
    tbl[2]  = '{1, 0, 0, 0, 0, O_FPGA,  0, 3};
    tbl[3]  = '{1, 0, 1, 0, 1, O_FPGA,  0, 3};  // enter/end_User ignored
    tbl[4]  = '{0, 1, 0, 0, 0, O_USER,  0, 3};
    tbl[5]  = '{1, 1, 0, 0, 1, O_USER,  0, 3};  // wrong-state pulses
    tbl[6]  = '{0, 0, 1, 0, 0, O_CHECK, 0, 3};
    tbl[7]  = '{0, 0, 0, 0, 1, O_R2,    0, 3};  // NEXT_ROUND
    tbl[8]  = '{0, 0, 0, 0, 0, O_FPGA,  1, 3};
    tbl[9]  = '{0, 1, 0, 0, 0, O_USER,  1, 3};
    tbl[10] = '{0, 0, 1, 0, 0, O_CHECK, 1, 3};
    tbl[11] = '{0, 0, 0, 0, 0, O_R2,    1, 3};  // LOSE with retry
    tbl[12] = '{0, 0, 0, 0, 0, O_FPGA,  1, 2};  // same round replayed

    reset = 1'b1;
    enter = 0; end_FPGA = 0; end_User = 0; key_press = 0; match = 0;
    model_reset();
    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("reset_state", int'({dut_o, round, lives}), int'({O_RST, 2'd0, 3'd3}));
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].en, tbl[i].ef, tbl[i].eu, tbl[i].kp, tbl[i].m, "tbl_model");
      vr = 2'(tbl[i].rnd);
      vl = 3'(tbl[i].lv);
      chk($sformatf("vec%0d", i), int'({dut_o, round, lives}), int'({tbl[i].o, vr, vl}));
    end

    // Timeout with no key press: 8 cycles in PLAY_USER, then LOSE.
    tick(0, 1, 0, 0, 0, "to_start");
    idle(7);
    chk("to_hold", int'(dut_o), int'(O_USER));
    idle(1);
    chk("to_lose", int'({dut_o, lives}), int'({O_R2, 3'd2}));
    idle(1);
    chk("to_replay", int'({dut_o, round, lives}), int'({O_FPGA, 2'd1, 3'd1}));

    // Key press at cycle 6 delays; key press on the expiry cycle wins.
    tick(0, 1, 0, 0, 0, "key_start");
    idle(6);
    tick(0, 0, 0, 1, 0, "key6");
    idle(7);
    chk("key_delay", int'(dut_o), int'(O_USER));
    tick(0, 0, 0, 1, 0, "key_vs_to");
    chk("key_vs_to_user", int'(dut_o), int'(O_USER));
    idle(8);
    chk("lose_last", int'({dut_o, lives}), int'({9'b0, 3'd1}));
    idle(1);
    chk("defeat", int'({dut_o, lives}), int'({O_RES_D, 3'd0}));
    tick(0, 1, 1, 1, 1, "res_ignore");
    chk("res_hold", int'(dut_o), int'(O_RES_D));
    tick(1, 0, 0, 0, 0, "res_enter");
    chk("restart_init", int'(dut_o), int'(O_INIT));
    idle(1);
    tick(1, 0, 0, 0, 0, "g2_enter");
    chk("g2_fpga", int'({dut_o, round, lives}), int'({O_FPGA, 2'd0, 3'd3}));

    // end_User on the expiry cycle goes to CHECK; then win the game.
    tick(0, 1, 0, 0, 0, "eu_start");
    idle(7);
    tick(0, 0, 1, 0, 0, "eu_vs_to");
    chk("eu_vs_to_check", int'(dut_o), int'(O_CHECK));
    tick(0, 0, 0, 0, 1, "g2_m0");
    chk("r2_pulse", int'(dut_o), int'(O_R2));
    idle(1);
    chk("round1", int'({dut_o, round}), int'({O_FPGA, 2'd1}));
    win_round();
    win_round();
    tick(0, 1, 0, 0, 0, "g2_r3_fpga");
    tick(0, 0, 1, 0, 0, "g2_r3_user");
    tick(0, 0, 0, 0, 1, "g2_r3_check");
    chk("victory", int'({dut_o, round}), int'({O_RES_V, 2'd3}));
    tick(1, 0, 0, 0, 0, "g2_restart");
    chk("victory_clear", int'(dut_o), int'(O_INIT));

    // Asynchronous reset in PLAY_USER at round 3.
    idle(1);
    tick(1, 0, 0, 0, 0, "g3_enter");
    win_round();
    win_round();
    win_round();
    tick(0, 1, 0, 0, 0, "g3_user");
    chk("g3_round3", int'({dut_o, round}), int'({O_USER, 2'd3}));
    #1 reset = 1'b1;
    #1;
    chk("async_reset", int'({dut_o, round, lives}), int'({O_RST, 2'd0, 3'd3}));
    model_reset();
    @(posedge CLOCK);
    @(negedge CLOCK);
    reset = 1'b0;
    chk_model("reset_hold");
    tick(0, 0, 0, 0, 0, "post_reset");
    chk("post_reset_setup", int'(dut_o), int'(O_SETUP));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
